// File: rtl/usb_fs_ep_arb_if.sv
// Endpoint-side bundle of the full-speed PE endpoint arbiter.
// Carries the requests, lane data and busy flag in, and the grant, mux and preempt results out.
interface usb_fs_ep_arb_if #(
   parameter int NUM_EPS = 4,
   parameter int DATA_W  = 8,
   parameter int IDX_W   = 4
);
   logic [NUM_EPS-1:0]        ep_req;
   logic [NUM_EPS-1:0]        ep_grant;
   logic [NUM_EPS*DATA_W-1:0] ep_data;
   logic                      pe_busy;
   logic                      arb_valid;
   logic [IDX_W-1:0]          arb_idx;
   logic [DATA_W-1:0]         arb_data;
   logic [NUM_EPS-1:0]        ep_preempt;

   modport master (
      output ep_req,
      output ep_data,
      output pe_busy,
      input  ep_grant,
      input  arb_valid,
      input  arb_idx,
      input  arb_data,
      input  ep_preempt
   );

   modport slave (
      input  ep_req,
      input  ep_data,
      input  pe_busy,
      output ep_grant,
      output arb_valid,
      output arb_idx,
      output arb_data,
      output ep_preempt
   );
endinterface

// File: rtl/usb_fs_ep_arb.sv
// Registered endpoint arbiter for the full-speed protocol engine: fixed-priority or round-robin,
// grant locked for the PE transaction, optional hold limit that preempts a hogging endpoint.
module usb_fs_ep_arb #(
   parameter int NUM_EPS  = 4,
   parameter int DATA_W   = 8,
   parameter int RR_MODE  = 1,
   parameter int MAX_HOLD = 0,
   parameter int IDX_W    = 4
) (
   input  logic           clk,
   input  logic           reset,
   usb_fs_ep_arb_if.slave bus
);

   localparam int                HOLD_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
   localparam bit                HOLD_EN  = (MAX_HOLD > 0);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_EPS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t              r_state;
   logic [NUM_EPS-1:0]  r_grant;
   logic [NUM_EPS-1:0]  r_preempt;
   logic                r_valid;
   logic [IDX_W-1:0]    r_idx;
   logic [IDX_W-1:0]    r_ptr;
   logic [HOLD_W-1:0]   r_hold;

   logic [IDX_W-1:0]    w_ptr_eff;
   logic [IDX_W-1:0]    w_idx_hi;
   logic [IDX_W-1:0]    w_idx_lo;
   logic                w_hit_hi;
   logic [IDX_W-1:0]    w_win_idx;
   logic [NUM_EPS-1:0]  w_win_oh;
   logic [IDX_W-1:0]    w_ptr_next;
   logic                w_req_g;
   logic                w_req_other;
   logic                w_hold_hit;
   logic                w_hold_inc;
   logic                w_preempt_fire;
   logic                w_to_idle;
   logic [DATA_W-1:0]   w_data;

   // Winner search: lowest requester at or above the pointer, else wrap to the lowest overall.
   always_comb begin
      w_ptr_eff = (RR_MODE != 0) ? r_ptr : {IDX_W{1'b0}};
      w_idx_hi  = {IDX_W{1'b0}};
      w_idx_lo  = {IDX_W{1'b0}};
      w_hit_hi  = 1'b0;
      w_win_oh  = {NUM_EPS{1'b0}};
      for (int i = NUM_EPS - 1; i >= 0; i--) begin
         w_idx_lo = bus.ep_req[i] ? IDX_W'(i) : w_idx_lo;
         w_idx_hi = (bus.ep_req[i] && (IDX_W'(i) >= w_ptr_eff)) ? IDX_W'(i) : w_idx_hi;
         w_hit_hi = w_hit_hi | (bus.ep_req[i] && (IDX_W'(i) >= w_ptr_eff));
      end
      w_win_idx = w_hit_hi ? w_idx_hi : w_idx_lo;
      for (int i = 0; i < NUM_EPS; i++) begin
         w_win_oh[i] = (IDX_W'(i) == w_win_idx);
      end
   end

   // Data lane mux driven by the registered grant; an empty grant yields zero.
   always_comb begin
      w_data = {DATA_W{1'b0}};
      for (int i = 0; i < NUM_EPS; i++) begin
         w_data = w_data | (bus.ep_data[i*DATA_W +: DATA_W] & {DATA_W{r_grant[i]}});
      end
   end

   assign w_req_g        = |(bus.ep_req & r_grant);
   assign w_req_other    = |(bus.ep_req & ~r_grant);
   assign w_hold_hit     = HOLD_EN && (r_hold == HOLD_MAX);
   assign w_hold_inc     = HOLD_EN && w_req_other && !bus.pe_busy && (r_hold != HOLD_MAX);
   assign w_ptr_next     = (r_idx == LAST_IDX) ? {IDX_W{1'b0}} : (r_idx + IDX_W'(1));
   assign w_preempt_fire = (r_state == ST_GRANT) && w_req_g && w_hold_hit && !bus.pe_busy;
   assign w_to_idle      = ((r_state == ST_GRANT) && (!w_req_g || w_hold_hit) && !bus.pe_busy) ||
                           ((r_state == ST_DRAIN) && !bus.pe_busy);

   // Arbiter state machine; grant, index, valid, preempt, pointer and hold counter are all registered here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_grant   <= {NUM_EPS{1'b0}};
         r_preempt <= {NUM_EPS{1'b0}};
         r_valid   <= 1'b0;
         r_idx     <= {IDX_W{1'b0}};
         r_ptr     <= {IDX_W{1'b0}};
         r_hold    <= {HOLD_W{1'b0}};
      end else begin
         r_preempt <= {NUM_EPS{1'b0}};
         if (w_to_idle) begin
            // Release (normal or preempted): pointer moves past the owner so the next search starts after it.
            r_state   <= ST_IDLE;
            r_grant   <= {NUM_EPS{1'b0}};
            r_valid   <= 1'b0;
            r_preempt <= w_preempt_fire ? r_grant : {NUM_EPS{1'b0}};
            if (RR_MODE != 0) begin
               r_ptr <= w_ptr_next;
            end
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (|bus.ep_req) begin
                     r_state <= ST_GRANT;
                     r_grant <= w_win_oh;
                     r_valid <= 1'b1;
                     r_idx   <= w_win_idx;
                     r_hold  <= {HOLD_W{1'b0}};
                  end
               end
               ST_GRANT: begin
                  if (!w_req_g) begin
                     r_state <= ST_DRAIN;
                  end else if (w_hold_inc) begin
                     r_hold <= r_hold + HOLD_W'(1);
                  end
               end
               ST_DRAIN: begin
                  r_state <= ST_DRAIN;
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_grant <= {NUM_EPS{1'b0}};
                  r_valid <= 1'b0;
                  r_hold  <= {HOLD_W{1'b0}};
               end
            endcase
         end
      end
   end

   assign bus.ep_grant   = r_grant;
   assign bus.arb_valid  = r_valid;
   assign bus.arb_idx    = r_idx;
   assign bus.arb_data   = w_data;
   assign bus.ep_preempt = r_preempt;

endmodule

// File: doc/usb_fs_ep_arb.md
# usb_fs_ep_arb

Parametrised, registered endpoint arbiter for the full-speed protocol engine; the successor to the combinational IN/OUT arbiters. It grants one of NUM_EPS endpoint requesters access to the shared PE datapath and muxes the winner's data. Selection is fixed-priority or round-robin, and the grant is locked for the whole PE transaction. An optional hold limit preempts an endpoint that hogs the grant while others wait. One instance sits on the IN side and one on the OUT side of the PE.

## Interface
- NUM_EPS, default 4: number of requesters, 1..16.
- DATA_W, default 8: width of each endpoint data lane.
- RR_MODE, default 1: 0 = fixed priority (lowest index wins); 1 = round-robin.
- MAX_HOLD, default 0: maximum cycles one grant may be held while others request. 0 = unlimited.
- IDX_W, default 4: width of grant index. Must be ≥ clog2(NUM_EPS), and at least 1.

Ports:
- clk, input, 1: 48 MHz clock.
- reset, input, 1: asynchronous, active-low reset.
- ep_req, input, NUM_EPS: per-endpoint request, level.
- ep_grant, output, NUM_EPS: one-hot or zero registered grant.
- ep_data, input, NUM_EPS*DATA_W: lane i is bits [i*DATA_W +: DATA_W].
- pe_busy, input, 1: PE mid-transaction; blocks any grant change except reset.
- arb_valid, output, 1: a grant is active (OR of ep_grant).
- arb_idx, output, IDX_W: index of the granted endpoint; holds its last value when idle.
- arb_data, output, DATA_W: lane of the granted endpoint; all zeros when idle.
- ep_preempt, output, NUM_EPS: one-cycle pulse on the endpoint whose grant was revoked by the hold limit.

## Operation
- State machine has three states:
  - IDLE: no grant.
  - GRANT: grant asserted and requester still requesting.
  - DRAIN: requester dropped ep_req but pe_busy is high; the grant stays asserted.
- IDLE → GRANT: when any ep_req bit is high, the winner is registered.
  - Fixed priority: lowest set index wins.
  - Round-robin: search starts at ptr and wraps modulo NUM_EPS.
- GRANT → DRAIN: ep_req[g] low and pe_busy high.
- GRANT → IDLE: ep_req[g] low and pe_busy low.
- DRAIN → IDLE: pe_busy low.
- DRAIN ignores ep_req[g] reasserting; the grant is released and re-arbitrated.
- Round-robin pointer: on every transition into IDLE, ptr ← (g+1) mod NUM_EPS, with wrap at NUM_EPS-1 → 0. Fixed-priority mode never updates ptr.
- Hold counter:
  - Clears on entering GRANT.
  - Increments each cycle in GRANT while another ep_req bit is high and pe_busy is low.
  - Saturates at MAX_HOLD.
  - When it equals MAX_HOLD (MAX_HOLD>0), the next edge goes to IDLE, pulses ep_preempt[g] and advances ptr as normal.
  - pe_busy high freezes the counter and suppresses preemption.
- arb_data: combinational mux of ep_data selected by the registered grant.
- NUM_EPS=1: the arbitration result is always index 0. The state machine and the hold logic still apply.

## Timing
- Reset (asynchronous, reset low) sets: ep_grant=0, arb_valid=0, arb_idx=0, ep_preempt=0, ptr=0, state IDLE, hold counter 0.
- Grant latency: ep_req sampled high at edge n (in IDLE) → ep_grant high after edge n.
- Release: a release condition sampled at edge t → grant low after t. Arbitration runs on the next edge, so there is always exactly one IDLE cycle between consecutive grants, including on preemption.
- Simultaneous requests in one cycle: exactly one winner, per mode.
- New requests arriving during GRANT/DRAIN are not lost. They are held as level requests and arbitrated in IDLE.
- ep_preempt is high for exactly the one cycle in which ep_grant first reads zero.
- arb_data follows ep_data of the granted lane with zero-cycle latency.
- Reset asserted mid-grant: outputs are zero immediately (asynchronous), with no preempt pulse.

## Test plan
- Single request: ep_req=4'b0100 held → ep_grant=4'b0100 one cycle later, arb_idx=2. Set ep_data lane2=8'hA5 → arb_data=8'hA5. Drop ep_req → ep_grant=0 next cycle, arb_data=8'h00.
- Round-robin fairness (RR_MODE=1): ep_req=4'b1111 held, each grant released by toggling that bit low for one cycle → grant order 0,1,2,3,0, with a one-cycle gap between grants.
- Fixed priority (RR_MODE=0): same stimulus as the fairness test → grant returns to 0 every time.
- Busy lock: grant ep1, assert pe_busy, drop ep_req[1], raise ep_req[0] → ep_grant stays 4'b0010 until pe_busy falls. Then 1 idle cycle, then grant ep0 in fixed-priority mode.
- Preemption (MAX_HOLD=3): ep0 holds req, ep1 requests, pe_busy=0 → after 3 counted cycles ep_grant→0 and ep_preempt=4'b0001 for one cycle; next cycle ep_grant=4'b0010. Repeat with pe_busy=1 → no preemption.
- Async reset mid-DRAIN: reset low between edges → all outputs 0 before the next edge. After release, ep_req=4'b1000 → ep_grant=4'b1000 one cycle later (ptr=0).
